// File: rtl/blackjack_engine.sv
// blackjack_engine: buffers a shuffled deck, deals P/D/P/D, runs player hit/stand and dealer play
// to a registered result with soft/hard ace totals.
module blackjack_engine #(
    parameter int DECK_DEPTH   = 16,
    parameter int HAND_MAX     = 6,
    parameter int CARD_W       = 4,
    parameter int DEALER_STAND = 17,
    parameter int HIT_SOFT17   = 0,
    parameter int TOT_W        = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              draw,
    input  logic              stand,
    input  logic              load_valid,
    input  logic [CARD_W-1:0] load_card,
    output logic              load_ready,
    input  logic              rd_dealer,
    input  logic [2:0]        rd_idx,
    output logic [CARD_W-1:0] rd_card,
    output logic [TOT_W-1:0]  player_total,
    output logic [TOT_W-1:0]  dealer_total,
    output logic              player_soft,
    output logic [3:0]        state_out,
    output logic [1:0]        result,
    output logic              result_valid
);
    localparam int PW = $clog2(DECK_DEPTH + 1);
    localparam int DW = $clog2(DECK_DEPTH);
    localparam int HW = $clog2(HAND_MAX + 1);
    localparam int IW = $clog2(HAND_MAX);
    localparam logic [PW-1:0]    DMAX = PW'(DECK_DEPTH);
    localparam logic [HW-1:0]    HMAX = HW'(HAND_MAX);
    localparam logic [TOT_W-1:0] T21  = TOT_W'(21);
    localparam logic [TOT_W-1:0] T17  = TOT_W'(17);
    localparam logic [TOT_W-1:0] TST  = TOT_W'(DEALER_STAND);

    typedef enum logic [3:0] {IDLE, LOAD, DEAL, P_CHECK, PLAYER, DEALER, D_CHECK, COMPARE, DONE} state_t;
    state_t state, next;

    logic [CARD_W-1:0] deck [DECK_DEPTH];
    logic [CARD_W-1:0] p_hand [HAND_MAX];
    logic [CARD_W-1:0] d_hand [HAND_MAX];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [1:0]        deal_cnt;
    logic [TOT_W-1:0]  p_hard, d_hard;
    logic [HW-1:0]     p_aces, d_aces, p_cnt, d_cnt;
    logic              p_wr, d_wr, clr, res_en, d_soft, d_stand, deck_empty;
    logic [1:0]        res_nxt;
    logic [CARD_W-1:0] top_card, rd_sel;

    function automatic logic [TOT_W-1:0] value(input logic [CARD_W-1:0] c);
        return (c >= CARD_W'(2) && c <= CARD_W'(10)) ? TOT_W'(c) :
               (c == CARD_W'(1)) ? TOT_W'(1) : TOT_W'(10);
    endfunction

    assign player_soft  = p_aces != '0 && p_hard + TOT_W'(10) <= T21;
    assign d_soft       = d_aces != '0 && d_hard + TOT_W'(10) <= T21;
    assign player_total = player_soft ? p_hard + TOT_W'(10) : p_hard;
    assign dealer_total = d_soft ? d_hard + TOT_W'(10) : d_hard;
    assign top_card     = deck[rd_ptr[DW-1:0]];
    assign deck_empty   = rd_ptr == DMAX;
    assign d_stand      = (dealer_total >= TST && !(HIT_SOFT17 != 0 && d_soft && dealer_total == T17))
                          || d_cnt == HMAX;
    assign load_ready   = state == LOAD;
    assign result_valid = state == DONE;
    assign state_out    = state;
    assign rd_sel       = rd_dealer ? d_hand[rd_idx[IW-1:0]] : p_hand[rd_idx[IW-1:0]];
    assign rd_card      = int'(rd_idx) < HAND_MAX ? rd_sel : '0;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next;

    always_comb begin
        next    = state;
        p_wr    = 1'b0;
        d_wr    = 1'b0;
        clr     = 1'b0;
        res_en  = 1'b0;
        res_nxt = 2'b00;
        case (state)
            IDLE, DONE: if (start) begin
                next = LOAD;
                clr  = 1'b1;
            end
            LOAD: if (load_valid && wr_ptr == DMAX - PW'(1)) next = DEAL;
            DEAL: begin
                p_wr = !deal_cnt[0];
                d_wr = deal_cnt[0];
                if (deal_cnt == 2'd3) next = P_CHECK;
            end
            P_CHECK: begin
                res_en  = player_total > T21;
                res_nxt = 2'b01;
                next    = res_en ? DONE : (player_total == T21 || p_cnt == HMAX) ? DEALER : PLAYER;
            end
            PLAYER: begin
                // stand wins over a same-cycle draw; a draw from an empty deck aborts
                res_en  = !stand && draw && deck_empty;
                res_nxt = 2'b11;
                p_wr    = !stand && draw && !deck_empty;
                next    = stand ? DEALER : res_en ? DONE : p_wr ? P_CHECK : PLAYER;
            end
            DEALER: begin
                res_en  = !d_stand && deck_empty;
                res_nxt = 2'b11;
                d_wr    = !d_stand && !deck_empty;
                next    = d_stand ? COMPARE : res_en ? DONE : D_CHECK;
            end
            D_CHECK: begin
                res_en  = dealer_total > T21;
                res_nxt = 2'b00;
                next    = res_en ? DONE : DEALER;
            end
            COMPARE: begin
                res_en  = 1'b1;
                res_nxt = player_total > dealer_total ? 2'b00 :
                          player_total < dealer_total ? 2'b01 : 2'b10;
                next    = DONE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (state == LOAD && load_valid) deck[wr_ptr[DW-1:0]] <= load_card;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            deal_cnt <= '0;
            p_hard   <= '0;
            d_hard   <= '0;
            p_aces   <= '0;
            d_aces   <= '0;
            p_cnt    <= '0;
            d_cnt    <= '0;
            result   <= '0;
            for (int i = 0; i < HAND_MAX; i++) begin
                p_hand[i] <= '0;
                d_hand[i] <= '0;
            end
        end else begin
            if (state == LOAD && load_valid) wr_ptr <= wr_ptr + PW'(1);
            if (state == DEAL) deal_cnt <= deal_cnt + 2'd1;
            if (p_wr) begin
                p_hand[p_cnt[IW-1:0]] <= top_card;
                p_hard <= p_hard + value(top_card);
                p_aces <= p_aces + HW'(top_card == CARD_W'(1));
                p_cnt  <= p_cnt + HW'(1);
            end
            if (d_wr) begin
                d_hand[d_cnt[IW-1:0]] <= top_card;
                d_hard <= d_hard + value(top_card);
                d_aces <= d_aces + HW'(top_card == CARD_W'(1));
                d_cnt  <= d_cnt + HW'(1);
            end
            if (p_wr || d_wr) rd_ptr <= rd_ptr + PW'(1);
            if (res_en) result <= res_nxt;
        end
    end
endmodule
